// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
// Size codes, FSM states and the byte-enable lookup used by the align datapath.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam int DWORD_BYTES = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } lsu_state_e;

   // Byte enables for an access of the given size, anchored at byte 0.
   function automatic logic [7:0] size_mask(input logic [1:0] size);
      case (size)
         SZ_B:    return 8'h01;
         SZ_H:    return 8'h03;
         SZ_W:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane datapath: extracts and extends load data, and merges
// sub-dword store data into a read-back dword. No state, no backpressure.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [63:0] ld_rdata,
   input  logic [2:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [63:0] ld_data,
   input  logic [63:0] st_old,
   input  logic [63:0] st_wdata,
   output logic [63:0] st_data
);

   logic [63:0] ld_shift;
   logic [63:0] st_shift;
   logic [7:0]  st_be;

   always_comb begin
      ld_shift = ld_rdata >> {offset, 3'b000};
      case (size)
         SZ_B:    ld_data = is_unsigned ? {56'd0, ld_shift[7:0]}  : {{56{ld_shift[7]}},  ld_shift[7:0]};
         SZ_H:    ld_data = is_unsigned ? {48'd0, ld_shift[15:0]} : {{48{ld_shift[15]}}, ld_shift[15:0]};
         SZ_W:    ld_data = is_unsigned ? {32'd0, ld_shift[31:0]} : {{32{ld_shift[31]}}, ld_shift[31:0]};
         default: ld_data = ld_shift;
      endcase
   end

   // Requests reaching here are aligned, so the shifted enables never spill past byte 7.
   always_comb begin
      st_shift = st_wdata << {offset, 3'b000};
      st_be    = size_mask(size) << offset;
      st_data  = st_old;
      for (int i = 0; i < DWORD_BYTES; i++) begin
         if (st_be[i]) begin
            st_data[8*i +: 8] = st_shift[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, RMW for sub-dword stores.
// Latency: fault 1, load/dword store 2, sub-dword store 3; response held until resp_ready.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_BYTES = 2048
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [63:0] address,
   output logic [63:0] write_data,
   input  logic [63:0] read_data
);

   lsu_state_e  state_q, state_d;
   logic        is_store_q, is_store_d;
   logic [1:0]  size_q, size_d;
   logic        unsigned_q, unsigned_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [63:0] address_q, address_d;
   logic [63:0] write_data_q, write_data_d;
   logic        resp_valid_q, resp_valid_d;
   logic [63:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   logic        misaligned;
   logic        fault;
   logic [63:0] ld_data;
   logic [63:0] st_data;

   lsu_align u_align (
      .ld_rdata    (read_data),
      .offset      (addr_q[2:0]),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .ld_data     (ld_data),
      .st_old      (read_data),
      .st_wdata    (wdata_q),
      .st_data     (st_data)
   );

   always_comb begin
      case (req_size)
         SZ_B:    misaligned = 1'b0;
         SZ_H:    misaligned = req_addr[0];
         SZ_W:    misaligned = |req_addr[1:0];
         default: misaligned = |req_addr[2:0];
      endcase
      fault = misaligned || (req_addr >= 64'(MEM_BYTES));
   end

   always_comb begin
      state_d      = state_q;
      is_store_d   = is_store_q;
      size_d       = size_q;
      unsigned_d   = unsigned_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      write_data_d = 64'd0;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               is_store_d   = req_is_store;
               size_d       = req_size;
               unsigned_d   = req_unsigned;
               addr_d       = req_addr;
               wdata_d      = req_wdata;
               resp_rdata_d = 64'd0;
               resp_err_d   = 1'b0;
               if (fault) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_is_store && req_size == SZ_D) begin
                  state_d      = WR;
                  write_data_d = req_wdata;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            if (is_store_q) begin
               state_d      = WR;
               write_data_d = st_data;
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = ld_data;
            end
         end
         WR: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         default: begin
            if (resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
               resp_rdata_d = 64'd0;
               resp_err_d   = 1'b0;
            end
         end
      endcase

      // Memory-side outputs are registered off the next state so they line up with RD/WR.
      mem_read_d  = (state_d == RD);
      mem_write_d = (state_d == WR);
      address_d   = (mem_read_d || mem_write_d) ? {addr_d[63:3], 3'b000} : 64'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         is_store_q   <= 1'b0;
         size_q       <= 2'd0;
         unsigned_q   <= 1'b0;
         addr_q       <= 64'd0;
         wdata_q      <= 64'd0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         address_q    <= 64'd0;
         write_data_q <= 64'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 64'd0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         is_store_q   <= is_store_d;
         size_q       <= size_d;
         unsigned_q   <= unsigned_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         address_q    <= address_d;
         write_data_q <= write_data_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign MemRead    = mem_read_q;
   assign MemWrite   = mem_write_q;
   assign address    = address_q;
   assign write_data = write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a dword-granular memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_is_store, req_unsigned;
   logic [1:0]  req_size;
   logic [63:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [63:0] resp_rdata;
   logic        MemRead, MemWrite;
   logic [63:0] address, write_data, read_data;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_BYTES(2048)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_is_store(req_is_store), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .MemRead(MemRead), .MemWrite(MemWrite),
      .address(address), .write_data(write_data), .read_data(read_data)
   );

   logic [63:0] mem [0:255];
   logic        mem_clr;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 64'd0;
      end else if (MemWrite && address < 64'd2048) begin
         mem[address[10:3]] <= write_data;
      end
   end

   assign read_data = (address < 64'd2048) ? mem[address[10:3]] : 64'd0;

   int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
   logic [63:0] rd_addr_seen, wr_addr_seen, wr_data_seen;

   always @(negedge clk) begin
      if (MemRead)  begin rd_cnt++; rd_addr_seen = address; end
      if (MemWrite) begin wr_cnt++; wr_addr_seen = address; wr_data_seen = write_data; end
      if (MemRead && MemWrite) both_cnt++;
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic run_req(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] rdata, output logic err,
                          output int lat, output int nrd, output int nwr);
      int r0, w0;
      @(negedge clk);
      req_is_store = st; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd; req_valid = 1'b1;
      r0 = rd_cnt; w0 = wr_cnt;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 20);
      rdata = resp_rdata;
      err   = resp_err;
      nrd   = rd_cnt - r0;
      nwr   = wr_cnt - w0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   task automatic req_chk(input string tag, input logic st, input logic [1:0] sz,
                          input logic uns, input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_nrd, input int exp_nwr);
      logic [63:0] rdata;
      logic        err;
      int          lat, nrd, nwr;
      run_req(st, sz, uns, a, wd, rdata, err, lat, nrd, nwr);
      check({tag, ".lat"},   64'(lat), 64'(exp_lat));
      check({tag, ".rdata"}, rdata, exp_rdata);
      check({tag, ".err"},   64'(err), 64'(exp_err));
      check({tag, ".nrd"},   64'(nrd), 64'(exp_nrd));
      check({tag, ".nwr"},   64'(nwr), 64'(exp_nwr));
   endtask

   initial begin
      int w0;
      rst_n = 1'b0; mem_clr = 1'b1; resp_ready = 1'b0;
      req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
      repeat (2) @(posedge clk);
      #1 mem_clr = 1'b0;
      @(negedge clk);
      check("rst.req_ready",  64'(req_ready), 64'd1);
      check("rst.MemRead",    64'(MemRead), 64'd0);
      check("rst.MemWrite",   64'(MemWrite), 64'd0);
      check("rst.address",    address, 64'd0);
      check("rst.write_data", write_data, 64'd0);
      check("rst.resp_valid", 64'(resp_valid), 64'd0);
      check("rst.resp_rdata", resp_rdata, 64'd0);
      check("rst.resp_err",   64'(resp_err), 64'd0);
      rst_n = 1'b1;

      req_chk("st_d_10", 1, 2'd3, 0, 64'h10, 64'h8877665544332211, 64'd0, 0, 2, 0, 1);
      check("st_d_10.wdata", wr_data_seen, 64'h8877665544332211);
      check("st_d_10.waddr", wr_addr_seen, 64'h10);

      req_chk("ld_d_10", 0, 2'd3, 0, 64'h10, 64'd0, 64'h8877665544332211, 0, 2, 1, 0);
      check("ld_d_10.raddr", rd_addr_seen, 64'h10);
      req_chk("ld_b_17s", 0, 2'd0, 0, 64'h17, 64'd0, 64'hFFFFFFFFFFFFFF88, 0, 2, 1, 0);
      check("ld_b_17s.raddr", rd_addr_seen, 64'h10);
      req_chk("ld_b_17u", 0, 2'd0, 1, 64'h17, 64'd0, 64'h0000000000000088, 0, 2, 1, 0);
      req_chk("ld_h_12s", 0, 2'd1, 0, 64'h12, 64'd0, 64'h0000000000004433, 0, 2, 1, 0);
      req_chk("ld_h_16s", 0, 2'd1, 0, 64'h16, 64'd0, 64'hFFFFFFFFFFFF8877, 0, 2, 1, 0);
      req_chk("ld_w_14s", 0, 2'd2, 0, 64'h14, 64'd0, 64'hFFFFFFFF88776655, 0, 2, 1, 0);
      req_chk("ld_w_14u", 0, 2'd2, 1, 64'h14, 64'd0, 64'h0000000088776655, 0, 2, 1, 0);

      req_chk("st_h_12", 1, 2'd1, 0, 64'h12, 64'h123400000000BEEF, 64'd0, 0, 3, 1, 1);
      check("st_h_12.wdata", wr_data_seen, 64'h88776655BEEF2211);
      check("st_h_12.waddr", wr_addr_seen, 64'h10);
      req_chk("ld_after_h", 0, 2'd3, 0, 64'h10, 64'd0, 64'h88776655BEEF2211, 0, 2, 1, 0);
      req_chk("st_b_17", 1, 2'd0, 0, 64'h17, 64'hFFFFFFFFFFFFFFAA, 64'd0, 0, 3, 1, 1);
      check("st_b_17.wdata", wr_data_seen, 64'hAA776655BEEF2211);

      req_chk("flt_w_13",  0, 2'd2, 0, 64'h13,  64'd0, 64'd0, 1, 1, 0, 0);
      req_chk("flt_d_800", 1, 2'd3, 0, 64'h800, 64'h1, 64'd0, 1, 1, 0, 0);
      req_chk("ld_d_7f8",  0, 2'd3, 0, 64'h7F8, 64'd0, 64'd0, 0, 2, 1, 0);

      // Response stall with a competing request on the input.
      @(negedge clk);
      req_is_store = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
      req_addr = 64'h10; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("bp.resp_valid0", 64'(resp_valid), 64'd1);
      req_is_store = 1'b1; req_size = 2'd3; req_addr = 64'h18;
      req_wdata = 64'hDEADBEEFCAFEF00D; req_valid = 1'b1;
      w0 = wr_cnt;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("bp.resp_valid%0d", i), 64'(resp_valid), 64'd1);
         check($sformatf("bp.rdata%0d", i), resp_rdata, 64'hAA776655BEEF2211);
         check($sformatf("bp.req_ready%0d", i), 64'(req_ready), 64'd0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      check("bp.resp_valid_clr", 64'(resp_valid), 64'd0);
      check("bp.req_ready_ret", 64'(req_ready), 64'd1);
      check("bp.no_write", 64'(wr_cnt - w0), 64'd0);
      req_chk("bp.ld_18", 0, 2'd3, 0, 64'h18, 64'd0, 64'd0, 0, 2, 1, 0);

      // Reset during the read half of a read-modify-write.
      req_chk("st_d_20", 1, 2'd3, 0, 64'h20, 64'h0123456789ABCDEF, 64'd0, 0, 2, 0, 1);
      @(negedge clk);
      req_is_store = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 64'h21; req_wdata = 64'h55; req_valid = 1'b1;
      w0 = wr_cnt;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rmid.MemRead_rd", 64'(MemRead), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rmid.MemRead_rst", 64'(MemRead), 64'd0);
      check("rmid.MemWrite_rst", 64'(MemWrite), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rmid.req_ready", 64'(req_ready), 64'd1);
      check("rmid.no_write", 64'(wr_cnt - w0), 64'd0);
      req_chk("rmid.ld_20", 0, 2'd3, 0, 64'h20, 64'd0, 64'h0123456789ABCDEF, 0, 2, 1, 0);

      check("rd_wr_overlap", 64'(both_cnt), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port: drives MemRead/MemWrite/address/write_data and samples read_data.
- Accepts one load/store request at a time from the pipeline MEM stage over a valid/ready handshake.
- Performs little-endian byte/half/word/dword accesses, with sign or zero extension on loads.
- Sub-dword stores use read-modify-write, because the memory is dword-granular only.

Parameters:
- MEM_BYTES, 2048, addressable data-memory size in bytes. Requests with addr >= MEM_BYTES fault.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; equals (state==IDLE)
- req_is_store  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword
- req_unsigned  in  1  loads: zero-extend when 1, else sign-extend
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-justified
- resp_valid  out  1  response held until resp_ready
- resp_ready  in  1  pipeline accepts response
- resp_rdata  out  64  extended load data; 0 for stores and faults
- resp_err  out  1  misaligned or out-of-range; no memory access performed
- MemRead  out  1  to data memory
- MemWrite  out  1  to data memory, asserted exactly one cycle per write
- address  out  64  to data memory, always {addr[63:3],3'b000}
- write_data  out  64  to data memory
- read_data  in  64  from data memory, combinational

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all latched request fields cleared.
  - MemRead=0, MemWrite=0, address=0, write_data=0, resp_valid=0, resp_rdata=0, resp_err=0.
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On req_valid, latch all request fields, then:
  - Fault (addr not aligned to 1<<size, or addr >= MEM_BYTES): go to RESP with resp_err=1.
  - Load: go to RD.
  - Dword store: go to WR.
  - Sub-dword store: go to RD.
- RD:
  - MemRead=1, address=aligned addr; read_data sampled at the end of the cycle.
  - Load: extract lane at byte offset addr[2:0] (shift right 8*offset), extend per size/unsigned, then go to RESP.
  - Store: merge req_wdata low bytes into sampled dword at offset addr[2:0] (byte enables from size), then go to WR.
- WR:
  - MemWrite=1, MemRead=0, write_data = merged (or full) dword. Go to RESP.
- RESP:
  - resp_valid=1, with resp_rdata/resp_err stable; MemRead=MemWrite=0.
  - On resp_ready: go to IDLE and clear resp_valid.
  - resp_ready=1 in the first RESP cycle completes the request in that cycle.
- Latency, accept edge to first resp_valid cycle:
  - load 2 cycles; dword store 2; sub-dword store 3; fault 1.
- Throughput: next request accepted no earlier than the cycle after RESP is consumed; no overlap.
- Memory-side outputs are registered; MemRead and MemWrite are never high in the same cycle.
- All memory-side outputs are 0 in IDLE and RESP.
- Reset mid-operation aborts immediately. A write already issued in WR stands; no partial write is issued otherwise.
- req_valid is ignored outside IDLE.
- req_* fields are don't-care after the accept cycle.

Decomposition:
- lsu_pkg:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D.
  - state enum {IDLE,RD,WR,RESP}.
  - DWORD_BYTES=8.
  - function size_mask(size) -> 8-bit byte-enable.
- Sub-module lsu_align (combinational):
  - load path: (rdata, offset, size, unsigned) -> extended data.
  - store path: (old dword, wdata, offset, size) -> merged dword.

Test Plan:
- Dword load: mem[0x10]=0x8877665544332211; load size=3 addr=0x10 -> MemRead high 1 cycle at address 0x10; resp_rdata=0x8877665544332211 two cycles after accept.
- Signed/unsigned byte: same dword, load byte addr=0x17:
  - signed -> 0xFFFFFFFFFFFFFF88.
  - unsigned -> 0x0000000000000088.
- Sub-dword store RMW: store half 0xBEEF at addr=0x12 -> RD then WR; write_data=0x88776655BEEF2211; resp_valid 3 cycles after accept; a subsequent dword load returns the same value.
- Faults, both resp_err=1 after 1 cycle with no MemRead/MemWrite pulse:
  - word load at addr=0x13 (misaligned).
  - dword store at addr=0x800 (= MEM_BYTES).
- Backpressure: resp_ready held 0 for 4 cycles -> resp_valid and data stable, req_ready=0, a new req_valid ignored; accepted only after resp_ready.
- Reset mid-op: assert rst_n=0 during RD of a sub-dword store -> MemRead drops immediately, no MemWrite, memory unchanged, req_ready=1 after release.
